// File: rtl/abm_ram_writer.sv
// Streams AXI-S frames into one of two RAMs (1-cycle write latency) and
// zero-sweeps both RAMs on reset or on a clear request.
module abm_ram_writer #(
   parameter int unsigned DW = 512,
   parameter int unsigned DD = 16384,
   localparam int unsigned AW = $clog2(DD)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [DW-1:0] axis_tdata,
   input  logic          axis_tvalid,
   input  logic          axis_tlast,
   output logic          axis_tready,
   input  logic          ram_sel,
   input  logic          clear,
   output logic [AW-1:0] ram_waddr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram0_we,
   output logic          ram1_we,
   output logic          busy,
   output logic          frame_done,
   output logic          overflow
);

   typedef enum logic [1:0] {StClear, StIdle, StFrame} state_e;

   localparam logic [AW:0] Depth = (AW+1)'(DD);
   localparam logic [AW:0] One   = (AW+1)'(1);

   state_e      state_q;
   logic [AW:0] clr_cnt_q;
   logic [AW:0] beat_idx_q;
   logic        sel_q;
   logic        pend_q;

   logic        accept;
   logic        cur_sel;
   logic [AW:0] cur_idx;

   // The first beat of a frame takes index 0 and the live ram_sel; later beats
   // use the latched values.
   always_comb begin
      accept  = axis_tvalid & axis_tready;
      cur_sel = (state_q == StIdle) ? ram_sel : sel_q;
      cur_idx = (state_q == StIdle) ? '0 : beat_idx_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StClear;
         clr_cnt_q   <= '0;
         beat_idx_q  <= '0;
         sel_q       <= 1'b0;
         pend_q      <= 1'b0;
         ram_waddr   <= '0;
         ram_wdata   <= '0;
         ram0_we     <= 1'b0;
         ram1_we     <= 1'b0;
         axis_tready <= 1'b0;
         busy        <= 1'b1;
         frame_done  <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         ram0_we    <= 1'b0;
         ram1_we    <= 1'b0;
         frame_done <= 1'b0;
         case (state_q)
            StClear: begin
               if (clr_cnt_q == Depth) begin
                  state_q     <= StIdle;
                  busy        <= 1'b0;
                  axis_tready <= 1'b1;
               end else begin
                  ram_waddr <= clr_cnt_q[AW-1:0];
                  ram_wdata <= '0;
                  ram0_we   <= 1'b1;
                  ram1_we   <= 1'b1;
                  clr_cnt_q <= clr_cnt_q + One;
               end
            end
            StIdle, StFrame: begin
               if (accept) begin
                  sel_q <= cur_sel;
                  if (cur_idx < Depth) begin
                     ram_waddr  <= cur_idx[AW-1:0];
                     ram_wdata  <= axis_tdata;
                     ram0_we    <= ~cur_sel;
                     ram1_we    <= cur_sel;
                     beat_idx_q <= cur_idx + One;
                  end else begin
                     // Past the end of the RAM: swallow the beat, keep the address.
                     beat_idx_q <= cur_idx;
                     overflow   <= 1'b1;
                  end
                  if (axis_tlast) begin
                     frame_done <= 1'b1;
                     if (pend_q || clear) begin
                        // Sweep starts after this last beat's write cycle.
                        state_q     <= StClear;
                        clr_cnt_q   <= '0;
                        pend_q      <= 1'b0;
                        busy        <= 1'b1;
                        axis_tready <= 1'b0;
                        overflow    <= 1'b0;
                     end else begin
                        state_q <= StIdle;
                     end
                  end else begin
                     state_q <= StFrame;
                     if (clear) begin
                        pend_q <= 1'b1;
                     end
                  end
               end else if (state_q == StIdle && clear) begin
                  // Clear from idle: the entry edge already writes address 0.
                  state_q     <= StClear;
                  ram_waddr   <= '0;
                  ram_wdata   <= '0;
                  ram0_we     <= 1'b1;
                  ram1_we     <= 1'b1;
                  clr_cnt_q   <= One;
                  busy        <= 1'b1;
                  axis_tready <= 1'b0;
                  overflow    <= 1'b0;
               end else if (clear) begin
                  pend_q <= 1'b1;
               end
            end
            default: begin
               state_q <= StClear;
            end
         endcase
      end
   end

endmodule

// File: doc/abm_ram_writer.md
ABM_RAM_WRITER -- requirements
Module: abm_ram_writer

Interface
REQ-001 Parameter DW, default 512, RAM word width in bits (multiple of 8).
REQ-002 Parameter DD, default 16384, RAM depth in words (power of 2); AW = $clog2(DD).
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 axis_tdata  input  DW  stream data beat.
REQ-006 axis_tvalid  input  1  beat valid.
REQ-007 axis_tlast  input  1  last beat of frame.
REQ-008 axis_tready  output  1  block accepts beat.
REQ-009 ram_sel  input  1  target RAM for a frame; 0 = RAM0, 1 = RAM1.
REQ-010 clear  input  1  single-cycle request to zero both RAMs.
REQ-011 ram_waddr  output  AW  shared write address to both RAM write ports.
REQ-012 ram_wdata  output  DW  shared write data.
REQ-013 ram0_we, ram1_we  output  1 each  write enables.
REQ-014 busy  output  1  high while a clear sweep runs.
REQ-015 frame_done  output  1  one-cycle pulse when a frame's tlast beat is accepted.
REQ-016 overflow  output  1  sticky flag; a frame exceeded DD beats.

Function
REQ-017 States SHALL be CLEAR, IDLE, FRAME; all outputs registered.
REQ-018 CLEAR: axis_tready=0, busy=1; each cycle ram0_we=ram1_we=1, ram_wdata=0, ram_waddr counting 0..DD-1, one address per cycle.
REQ-019 After the write to address DD-1, next cycle SHALL be IDLE with busy=0, we=0, axis_tready=1; sweep takes exactly DD cycles.
REQ-020 IDLE and FRAME: axis_tready=1.
REQ-021 Beat accepted = axis_tvalid & axis_tready; write to RAM occurs on the cycle after acceptance (1-cycle latency): ram_wdata=beat data, ram_waddr=beat index, we of selected RAM=1, other we=0.
REQ-022 ram_sel SHALL be sampled on the first accepted beat of a frame (in IDLE) and held for the whole frame.
REQ-023 First beat of a frame writes address 0; each further beat writes previous address+1.
REQ-024 IDLE + accepted beat with tlast=0 -> FRAME; with tlast=1 -> stays IDLE (one-beat frame), frame_done pulses.
REQ-025 FRAME + accepted beat with tlast=1 -> IDLE, frame_done pulses the cycle after acceptance (aligned with that beat's we).
REQ-026 Beats with index >= DD SHALL not be written (we=0), address SHALL not wrap; overflow set to 1; beats still accepted until tlast.
REQ-027 frame_done SHALL pulse on the tlast of an overflowed frame as well.
REQ-028 clear in IDLE (no beat accepted same cycle) -> CLEAR next cycle, address 0.
REQ-029 clear in FRAME, or in IDLE coincident with an accepted beat, SHALL be latched as pending; CLEAR entered the cycle after that frame's tlast is accepted.
REQ-030 clear while in CLEAR SHALL be ignored (sweep not restarted).
REQ-031 overflow SHALL clear to 0 on entry to CLEAR; set has priority only within a frame, never on the CLEAR-entry cycle.
REQ-032 we asserted in no cycle other than those in REQ-018/REQ-021; both we never high outside CLEAR.

Reset
REQ-033 While resetn=0: state CLEAR, ram_waddr=0, ram0_we=ram1_we=0, ram_wdata=0, axis_tready=0, busy=1, frame_done=0, overflow=0, clear-pending=0, sampled ram_sel=0.
REQ-034 First rising edge after resetn deasserts starts the sweep at address 0 (REQ-018); reset asserted mid-sweep or mid-frame aborts immediately, frame discarded, sweep restarts from 0.

Verification
REQ-035 DD=16: release reset -> both we high 16 cycles, addr 0..15, data 0, busy=1; then tready=1, busy=0.
REQ-036 ram_sel=1, 4-beat frame data 0xA0..0xA3 back-to-back -> ram1_we on 4 cycles, addr 0..3, ram0_we=0, frame_done once with last write.
REQ-037 tvalid toggled every other cycle, 3-beat frame ram_sel=0, ram_sel flipped mid-frame -> all three writes to RAM0, addr 0..2, no gaps in address.
REQ-038 DD=16, 20-beat frame -> writes addr 0..15 only, overflow=1 after beat 16, frame_done on beat 20; subsequent clear -> overflow=0.
REQ-039 clear pulsed on beat 2 of a 5-beat frame -> all 5 beats written, then CLEAR starts cycle after tlast accepted; second clear during sweep -> sweep length still 16.
REQ-040 resetn pulled low on beat 3 of a frame -> we drop asynchronously, tready=0; after release full sweep from addr 0.
